// File: rtl/muldiv_ctrl_if.sv
// HI/LO unit pipeline-side bundle: EX-stage request in, busy and HI/LO out.
interface muldiv_ctrl_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        cancel;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output start, op, A, B, cancel,
      input  busy, HI, LO
   );

   modport slave (
      input  start, op, A, B, cancel,
      output busy, HI, LO
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// MIPS-style HI/LO multiply/divide controller. The result is computed at
// acceptance and held pending; the FSM then models the unit latency
// (5 cycles for multiply, 10 for divide) before writing HI/LO.
// Optional feature: define MULDIV_MADD_EN to enable MADD/MADDU (ops 6/7).
module muldiv_ctrl (
   input  logic         clk,
   input  logic         reset,
   muldiv_ctrl_if.slave bus
);

   typedef enum logic {IDLE, RUN} state_e;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_MADD  = 3'd6,
      OP_MADDU = 3'd7
   } op_e;

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic [63:0] pend_q;
   logic        busy_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   logic        accept;
   logic        launch_d;
   logic [3:0]  cnt_d;
   logic [63:0] pend_d;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] b_mag_safe;
   logic [31:0] b_u_safe;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] q_s;
   logic [31:0] r_s;
   logic [31:0] q_u;
   logic [31:0] r_u;

   assign accept = bus.start && !bus.cancel && (state_q == IDLE);

   // Operation result and latency selection for the instruction at acceptance
   always_comb begin
      // low 64 bits of the product of sign-extended operands equal the signed product
      prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
      prod_u = {32'd0, bus.A} * {32'd0, bus.B};

      // signed divide on magnitudes: avoids the -2^31 / -1 overflow corner and
      // yields truncation toward zero with the remainder taking the dividend sign
      a_neg      = bus.A[31];
      b_neg      = bus.B[31];
      a_mag      = a_neg ? (~bus.A + 32'd1) : bus.A;
      b_mag      = b_neg ? (~bus.B + 32'd1) : bus.B;
      b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
      b_u_safe   = (bus.B == 32'd0) ? 32'd1 : bus.B;
      q_mag      = a_mag / b_mag_safe;
      r_mag      = a_mag % b_mag_safe;
      q_s        = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
      r_s        = a_neg ? (~r_mag + 32'd1) : r_mag;
      q_u        = bus.A / b_u_safe;
      r_u        = bus.A % b_u_safe;

      launch_d = 1'b0;
      cnt_d    = 4'd0;
      pend_d   = {hi_q, lo_q};
      case (op_e'(bus.op))
         OP_MULT: begin
            launch_d = accept;
            cnt_d    = 4'd5;
            pend_d   = prod_s;
         end
         OP_MULTU: begin
            launch_d = accept;
            cnt_d    = 4'd5;
            pend_d   = prod_u;
         end
         // divide by zero keeps the current HI/LO as the pending value
         OP_DIV: begin
            launch_d = accept;
            cnt_d    = 4'd10;
            if (bus.B != 32'd0) pend_d = {r_s, q_s};
         end
         OP_DIVU: begin
            launch_d = accept;
            cnt_d    = 4'd10;
            if (bus.B != 32'd0) pend_d = {r_u, q_u};
         end
`ifdef MULDIV_MADD_EN
         OP_MADD: begin
            launch_d = accept;
            cnt_d    = 4'd5;
            pend_d   = {hi_q, lo_q} + prod_s;
         end
         OP_MADDU: begin
            launch_d = accept;
            cnt_d    = 4'd5;
            pend_d   = {hi_q, lo_q} + prod_u;
         end
`endif
         default: begin
            launch_d = 1'b0;
         end
      endcase
   end

   // Control FSM: accept in IDLE, count down in RUN, write back on the last cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         busy_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (launch_d) begin
                  pend_q  <= pend_d;
                  cnt_q   <= cnt_d;
                  state_q <= RUN;
                  busy_q  <= 1'b1;
               end else if (accept && (bus.op == OP_MTHI)) begin
                  hi_q <= bus.A;
               end else if (accept && (bus.op == OP_MTLO)) begin
                  lo_q <= bus.A;
               end
            end
            RUN: begin
               if (cnt_q == 4'd1) begin
                  hi_q    <= pend_q[63:32];
                  lo_q    <= pend_q[31:0];
                  cnt_q   <= '0;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

endmodule
